// File: rtl/sg7_scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : sg7_scan_decoder_if
//  Purpose  : Bundles the sniffed 7-segment display bus (segments + digit
//             enables) with the decoded frame outputs of sg7_scan_decoder.
//  Revision : 1.0  initial release
// ============================================================================
interface sg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              sg7;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    valid;
    logic                    seg_err;
    logic                    sel_err;

    // Display-bus side: drives segments/enables, observes decoded frames
    modport master (
        output sg7,
        output dig_en,
        input  value,
        input  valid,
        input  seg_err,
        input  sel_err
    );

    // Decoder side
    modport slave (
        input  sg7,
        input  dig_en,
        output value,
        output valid,
        output seg_err,
        output sel_err
    );
endinterface
`default_nettype wire

// File: rtl/sg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : sg7_scan_decoder
//  Purpose  : Sniffs a multiplexed common-digit 7-segment bus, debounces each
//             digit/segment pair, decodes it back to a nibble and assembles
//             a full NUM_DIGITS frame announced by a 1-cycle valid pulse.
//  Revision : 1.0  initial release
// ============================================================================
module sg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    sg7_scan_decoder_if.slave     bus
);

    localparam logic [CNT_W-1:0]      c_stable  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]      c_cnt_one = CNT_W'(1);
    localparam logic [NUM_DIGITS-1:0] c_dig_one = NUM_DIGITS'(1);

    typedef enum logic [0:0] {
        ST_TRACK = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Registered bus sample (pair P) and its stability counter
    logic [NUM_DIGITS-1:0]   r_dig;
    logic [6:0]              r_seg;
    logic [CNT_W-1:0]        r_cnt;

    // Partial frame being collected
    logic [4*NUM_DIGITS-1:0] r_buf;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic [NUM_DIGITS-1:0]   r_err;

    // Output registers
    logic [4*NUM_DIGITS-1:0] r_value;
    logic                    r_valid;
    logic                    r_seg_err;
    logic                    r_sel_err;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_eval;

    logic                    w_pair_change;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [3:0]              w_nibble;
    logic                    w_bad_pattern;
    logic                    w_any_dig;
    logic                    w_multi_dig;
    logic                    w_accept;
    logic                    w_sel_evt;
    logic                    w_complete;
    logic [NUM_DIGITS-1:0]   w_seen_upd;
    logic [NUM_DIGITS-1:0]   w_err_upd;
    logic [4*NUM_DIGITS-1:0] w_frame;

    // Segment pattern {g,f,e,d,c,b,a} back to a decimal digit; 4'hF marks garbage
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h3F:   res = {1'b0, 4'h0};
            7'h06:   res = {1'b0, 4'h1};
            7'h5B:   res = {1'b0, 4'h2};
            7'h4F:   res = {1'b0, 4'h3};
            7'h66:   res = {1'b0, 4'h4};
            7'h6D:   res = {1'b0, 4'h5};
            7'h7D:   res = {1'b0, 4'h6};
            7'h07:   res = {1'b0, 4'h7};
            7'h7F:   res = {1'b0, 4'h8};
            7'h6F:   res = {1'b0, 4'h9};
            default: res = {1'b1, 4'hF};
        endcase
        return res;
    endfunction

    // The counter looks at the incoming bus against the current sample, so
    // it counts in step with the sample register: the first edge that
    // captures a new pair also restarts the count at 1.
    always_comb begin
        w_pair_change = ({bus.dig_en, bus.sg7} != {r_dig, r_seg});
        if (w_pair_change) begin
            w_cnt_next = c_cnt_one;
        end else if (r_cnt == c_stable) begin
            w_cnt_next = c_stable;
        end else begin
            w_cnt_next = r_cnt + c_cnt_one;
        end
    end

    // Classify the current sample and build the would-be frame contents
    always_comb begin
        {w_bad_pattern, w_nibble} = decode_seg(r_seg);
        w_any_dig   = |r_dig;
        w_multi_dig = |(r_dig & (r_dig - c_dig_one));
        w_accept    = w_eval && w_any_dig && !w_multi_dig;
        w_sel_evt   = w_eval && w_multi_dig;
        w_seen_upd  = r_seen | r_dig;
        w_complete  = &w_seen_upd;
        w_frame     = r_buf;
        w_err_upd   = r_err;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_dig[k]) begin
                w_frame[4*k +: 4] = w_nibble;
                w_err_upd[k]      = w_bad_pattern;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_TRACK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: evaluate a settled pair exactly once, then wait for it to change
    always_comb begin
        w_state_next = r_state;
        w_eval       = 1'b0;
        case (r_state)
            ST_TRACK: begin
                if (r_cnt == c_stable) begin
                    w_eval       = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_cnt == c_cnt_one) begin
                    w_state_next = ST_TRACK;
                end
            end
            default: begin
                w_state_next = ST_TRACK;
            end
        endcase
    end

    // Sampling, frame assembly and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dig     <= '0;
            r_seg     <= '0;
            r_cnt     <= '0;
            r_buf     <= '0;
            r_seen    <= '0;
            r_err     <= '0;
            r_value   <= '0;
            r_valid   <= 1'b0;
            r_seg_err <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_dig     <= bus.dig_en;
            r_seg     <= bus.sg7;
            r_cnt     <= w_cnt_next;
            r_valid   <= 1'b0;
            r_sel_err <= w_sel_evt;
            if (w_accept) begin
                if (w_complete) begin
                    r_value   <= w_frame;
                    r_valid   <= 1'b1;
                    r_seg_err <= |w_err_upd;
                    r_seen    <= '0;
                    r_err     <= '0;
                end else begin
                    r_buf     <= w_frame;
                    r_seen    <= w_seen_upd;
                    r_err     <= w_err_upd;
                end
            end
        end
    end

    assign bus.value   = r_value;
    assign bus.valid   = r_valid;
    assign bus.seg_err = r_seg_err;
    assign bus.sel_err = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_sg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sg7_scan_decoder
//  Purpose  : Directed scoreboard bench for sg7_scan_decoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sg7_scan_decoder;

    typedef struct packed {
        logic [15:0] value;
        logic        seg_err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n_valid;
    int   n_sel;
    int   n_pushed;
    exp_t q[$];

    sg7_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

    sg7_scan_decoder #(
        .NUM_DIGITS   (4),
        .STABLE_CYCLES(4),
        .CNT_W        (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold one pair on the bus for n clocks (called at a falling edge)
    task automatic put(input logic [3:0] dig, input logic [6:0] seg, input int n);
        bus.dig_en = dig;
        bus.sg7    = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [15:0] v, input logic e);
        exp_t x;
        x.value   = v;
        x.seg_err = e;
        q.push_back(x);
        n_pushed++;
    endtask

    task automatic clean_frame(input int hold, input int gap);
        put(4'b0001, 7'h06, hold); put(4'b0000, 7'h00, gap);
        put(4'b0010, 7'h5B, hold); put(4'b0000, 7'h00, gap);
        put(4'b0100, 7'h4F, hold); put(4'b0000, 7'h00, gap);
        put(4'b1000, 7'h66, hold); put(4'b0000, 7'h00, gap);
    endtask

    // Monitor: every valid pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (!rst && bus.sel_err) n_sel++;
        if (!rst && bus.valid) begin
            exp_t x;
            n_valid++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got value %0h with nothing expected", bus.value);
            end else begin
                x = q.pop_front();
                if (bus.value !== x.value || bus.seg_err !== x.seg_err) begin
                    errors++;
                    $display("FAIL frame: got value %0h seg_err %0b expected value %0h seg_err %0b",
                             bus.value, bus.seg_err, x.value, x.seg_err);
                end
            end
        end
    end

    initial begin
        int v0;
        int s0;
        checks   = 0;
        errors   = 0;
        n_valid  = 0;
        n_sel    = 0;
        n_pushed = 0;
        rst        = 1'b1;
        bus.dig_en = 4'b0000;
        bus.sg7    = 7'h00;
        repeat (2) @(negedge clk);
        chk("reset_value",   32'(bus.value),   32'h0);
        chk("reset_valid",   32'(bus.valid),   32'h0);
        chk("reset_seg_err", 32'(bus.seg_err), 32'h0);
        chk("reset_sel_err", 32'(bus.sel_err), 32'h0);
        rst = 1'b0;
        put(4'b0000, 7'h00, 3);

        // 1: plain frame, 6 clocks per digit
        v0 = n_valid;
        expect_frame(16'h4321, 1'b0);
        clean_frame(6, 0);
        chk("t1_valid_count", 32'(n_valid - v0), 32'd1);
        put(4'b0000, 7'h00, 3);

        // 2: digit 2 too short to be accepted, then rescanned
        v0 = n_valid;
        put(4'b0001, 7'h06, 6);
        put(4'b0010, 7'h5B, 6);
        put(4'b0100, 7'h4F, 3);
        put(4'b1000, 7'h66, 6);
        chk("t2_no_valid_short_digit", 32'(n_valid - v0), 32'd0);
        expect_frame(16'h4321, 1'b0);
        put(4'b0100, 7'h4F, 6);
        chk("t2_valid_after_rescan", 32'(n_valid - v0), 32'd1);
        chk("t2_value_held", 32'(bus.value), 32'h4321);
        put(4'b0000, 7'h00, 3);

        // 3: invalid pattern on digit 1, then a clean frame clears seg_err
        expect_frame(16'h43F1, 1'b1);
        put(4'b0001, 7'h06, 6);
        put(4'b0010, 7'h7E, 6);
        put(4'b0100, 7'h4F, 6);
        put(4'b1000, 7'h66, 6);
        chk("t3_seg_err_held", 32'(bus.seg_err), 32'h1);
        expect_frame(16'h4321, 1'b0);
        clean_frame(6, 0);
        put(4'b0000, 7'h00, 3);

        // 4: multi-hot enable gives one sel_err pulse at edge 5 and no slot write
        v0 = n_valid;
        s0 = n_sel;
        bus.dig_en = 4'b0011;
        bus.sg7    = 7'h3F;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("t4_sel_err_edge%0d", i), 32'(bus.sel_err), (i == 5) ? 32'h1 : 32'h0);
        end
        chk("t4_sel_count", 32'(n_sel - s0), 32'd1);
        put(4'b0100, 7'h4F, 6);
        put(4'b1000, 7'h66, 6);
        chk("t4_no_valid", 32'(n_valid - v0), 32'd0);
        expect_frame(16'h4321, 1'b0);
        put(4'b0001, 7'h06, 6);
        put(4'b0010, 7'h5B, 6);
        chk("t4_valid_after_fill", 32'(n_valid - v0), 32'd1);
        put(4'b0000, 7'h00, 3);

        // 5: long holds with blanking gaps, two scans -> two frames
        v0 = n_valid;
        expect_frame(16'h4321, 1'b0);
        expect_frame(16'h4321, 1'b0);
        clean_frame(100, 3);
        clean_frame(100, 3);
        chk("t5_valid_count", 32'(n_valid - v0), 32'd2);

        // 6: reset discards a partial frame
        v0 = n_valid;
        put(4'b0001, 7'h06, 6);
        put(4'b0010, 7'h5B, 6);
        bus.dig_en = 4'b0000;
        bus.sg7    = 7'h00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_value_reset",   32'(bus.value),   32'h0);
        chk("t6_seg_err_reset", 32'(bus.seg_err), 32'h0);
        put(4'b0100, 7'h4F, 6);
        put(4'b1000, 7'h66, 6);
        chk("t6_no_valid", 32'(n_valid - v0), 32'd0);
        expect_frame(16'h4321, 1'b0);
        clean_frame(6, 0);
        chk("t6_valid_after_full", 32'(n_valid - v0), 32'd1);
        put(4'b0000, 7'h00, 5);

        chk("all_expected_seen", 32'(q.size()), 32'd0);
        chk("total_valid", 32'(n_valid), 32'(n_pushed));
        chk("total_sel_err", 32'(n_sel), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
